// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage for the ALU.
// Decodes instruction + register read data into ALU control/operands and
// presents them on a registered valid/ready output. A main output register
// plus one skid register allow full throughput with a registered s_ready.
module alu_issue #(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_instr,
    input  logic [31:0] s_pc,
    input  logic [31:0] s_rs1_data,
    input  logic [31:0] s_rs2_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_alu_ctrl,
    output logic [31:0] m_op_a,
    output logic [31:0] m_op_b,
    output logic [31:0] m_pc,
    output logic [4:0]  m_rd,
    output logic        m_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Register-register funct3 mapping shared by OP and OP-IMM: {illegal, ctrl}.
    // SLTU/SLTIU (011) has no ALU code and lands in the default.
    function automatic logic [4:0] decode_rr(input logic [2:0] f3);
        case (f3)
            3'b000:  decode_rr = {1'b0, ALU_ADD};
            3'b001:  decode_rr = {1'b0, ALU_SLL};
            3'b010:  decode_rr = {1'b0, ALU_SLT};
            3'b100:  decode_rr = {1'b0, ALU_XOR};
            3'b101:  decode_rr = {1'b0, ALU_SRL};
            3'b110:  decode_rr = {1'b0, ALU_OR};
            3'b111:  decode_rr = {1'b0, ALU_AND};
            default: decode_rr = {1'b1, ILLEGAL_CTRL};
        endcase
    endfunction

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_u_s;
    logic [4:0]  rr_s;

    assign opcode_s = s_instr[6:0];
    assign funct3_s = s_instr[14:12];
    assign funct7_s = s_instr[31:25];
    assign imm_i_s  = {{20{s_instr[31]}}, s_instr[31:20]};
    assign imm_s_s  = {{20{s_instr[31]}}, s_instr[31:25], s_instr[11:7]};
    assign imm_u_s  = {s_instr[31:12], 12'h000};
    assign rr_s     = decode_rr(funct3_s);

    logic        raw_illegal_s;
    logic [3:0]  raw_ctrl_s;
    logic [31:0] raw_op_a_s;
    logic [31:0] raw_op_b_s;

    // Instruction decode: pick ALU code and operand sources per opcode.
    always_comb begin
        raw_illegal_s = 1'b1;
        raw_ctrl_s    = ILLEGAL_CTRL;
        raw_op_a_s    = 32'h0000_0000;
        raw_op_b_s    = 32'h0000_0000;
        case (opcode_s)
            OPC_OP: begin
                raw_op_a_s = s_rs1_data;
                raw_op_b_s = s_rs2_data;
                if (funct7_s == 7'b0000000) begin
                    {raw_illegal_s, raw_ctrl_s} = rr_s;
                end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
                    {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_SUB};
                end else begin
                    {raw_illegal_s, raw_ctrl_s} = {1'b1, ILLEGAL_CTRL};
                end
            end
            OPC_OP_IMM: begin
                raw_op_a_s = s_rs1_data;
                case (funct3_s)
                    3'b001, 3'b101: begin
                        // Shift immediates: only the logical forms with funct7=0
                        raw_op_b_s = {27'h000_0000, s_instr[24:20]};
                        if (funct7_s == 7'b0000000) begin
                            {raw_illegal_s, raw_ctrl_s} = rr_s;
                        end else begin
                            {raw_illegal_s, raw_ctrl_s} = {1'b1, ILLEGAL_CTRL};
                        end
                    end
                    default: begin
                        raw_op_b_s = imm_i_s;
                        {raw_illegal_s, raw_ctrl_s} = rr_s;
                    end
                endcase
            end
            OPC_LOAD: begin
                {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_ADD};
                raw_op_a_s = s_rs1_data;
                raw_op_b_s = imm_i_s;
            end
            OPC_STORE: begin
                {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_ADD};
                raw_op_a_s = s_rs1_data;
                raw_op_b_s = imm_s_s;
            end
            OPC_BRANCH: begin
                raw_op_a_s = s_rs1_data;
                raw_op_b_s = s_rs2_data;
                case (funct3_s)
                    3'b000, 3'b001: {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_SUB};
                    3'b100, 3'b101: {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_SLT};
                    default:        {raw_illegal_s, raw_ctrl_s} = {1'b1, ILLEGAL_CTRL};
                endcase
            end
            OPC_LUI: begin
                {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_ADD};
                raw_op_b_s = imm_u_s;
            end
            OPC_AUIPC: begin
                {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_ADD};
                raw_op_a_s = s_pc;
                raw_op_b_s = imm_u_s;
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4 is computed by the ALU
                {raw_illegal_s, raw_ctrl_s} = {1'b0, ALU_ADD};
                raw_op_a_s = s_pc;
                raw_op_b_s = 32'h0000_0004;
            end
            default: begin
                {raw_illegal_s, raw_ctrl_s} = {1'b1, ILLEGAL_CTRL};
            end
        endcase
    end

    // Illegal entries always carry the fixed control code and zero operands
    logic [3:0]  dec_ctrl_s;
    logic [31:0] dec_op_a_s;
    logic [31:0] dec_op_b_s;
    assign dec_ctrl_s = raw_illegal_s ? ILLEGAL_CTRL  : raw_ctrl_s;
    assign dec_op_a_s = raw_illegal_s ? 32'h0000_0000 : raw_op_a_s;
    assign dec_op_b_s = raw_illegal_s ? 32'h0000_0000 : raw_op_b_s;

    logic        out_valid_r, skid_valid_r, s_ready_r;
    logic [3:0]  out_ctrl_r, skid_ctrl_r;
    logic [31:0] out_op_a_r, skid_op_a_r;
    logic [31:0] out_op_b_r, skid_op_b_r;
    logic [31:0] out_pc_r, skid_pc_r;
    logic [4:0]  out_rd_r, skid_rd_r;
    logic        out_illegal_r, skid_illegal_r;

    logic accept_s;
    logic out_free_s;
    assign accept_s   = s_valid && s_ready_r;
    assign out_free_s = !out_valid_r || m_ready;

    // Output/skid buffer: reset > flush > load/drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            skid_valid_r   <= 1'b0;
            s_ready_r      <= 1'b1;
            out_ctrl_r     <= 4'h0;
            out_op_a_r     <= 32'h0000_0000;
            out_op_b_r     <= 32'h0000_0000;
            out_pc_r       <= 32'h0000_0000;
            out_rd_r       <= 5'h00;
            out_illegal_r  <= 1'b0;
            skid_ctrl_r    <= 4'h0;
            skid_op_a_r    <= 32'h0000_0000;
            skid_op_b_r    <= 32'h0000_0000;
            skid_pc_r      <= 32'h0000_0000;
            skid_rd_r      <= 5'h00;
            skid_illegal_r <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            s_ready_r    <= 1'b1;
        end else if (out_free_s) begin
            // Output empty or draining: refill from skid first, then from input
            s_ready_r    <= 1'b1;
            skid_valid_r <= 1'b0;
            if (skid_valid_r) begin
                out_valid_r   <= 1'b1;
                out_ctrl_r    <= skid_ctrl_r;
                out_op_a_r    <= skid_op_a_r;
                out_op_b_r    <= skid_op_b_r;
                out_pc_r      <= skid_pc_r;
                out_rd_r      <= skid_rd_r;
                out_illegal_r <= skid_illegal_r;
            end else if (accept_s) begin
                out_valid_r   <= 1'b1;
                out_ctrl_r    <= dec_ctrl_s;
                out_op_a_r    <= dec_op_a_s;
                out_op_b_r    <= dec_op_b_s;
                out_pc_r      <= s_pc;
                out_rd_r      <= s_instr[11:7];
                out_illegal_r <= raw_illegal_s;
            end else begin
                out_valid_r   <= 1'b0;
            end
        end else if (accept_s) begin
            // Output stalled: park the new entry in the skid register
            skid_valid_r   <= 1'b1;
            s_ready_r      <= 1'b0;
            skid_ctrl_r    <= dec_ctrl_s;
            skid_op_a_r    <= dec_op_a_s;
            skid_op_b_r    <= dec_op_b_s;
            skid_pc_r      <= s_pc;
            skid_rd_r      <= s_instr[11:7];
            skid_illegal_r <= raw_illegal_s;
        end else begin
            s_ready_r <= !skid_valid_r;
        end
    end

    assign s_ready    = s_ready_r;
    assign m_valid    = out_valid_r;
    assign m_alu_ctrl = out_ctrl_r;
    assign m_op_a     = out_op_a_r;
    assign m_op_b     = out_op_b_r;
    assign m_pc       = out_pc_r;
    assign m_rd       = out_rd_r;
    assign m_illegal  = out_illegal_r;

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage for the RV32I core's ALU: accepts an instruction with its PC and register-file read data on a valid/ready input, decodes it into `alu_ctrl`/`op_a`/`op_b`, and presents the result to the execute stage on a registered valid/ready output. It is the initiator side of the ALU operand/control interface. A 2-entry skid buffer gives full throughput with a registered `s_ready`. Instructions the ALU cannot execute are flagged as illegal.

## Interface
- `ILLEGAL_CTRL`, default 4'b1111: `m_alu_ctrl` value driven for an illegal instruction. The ALU returns 0 for this value.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `flush` input 1: synchronous; discards all buffered entries.
- `s_valid` input 1: input entry valid.
- `s_ready` output 1: stage can accept an entry.
- `s_instr` input 32: RV32I instruction word.
- `s_pc` input 32: instruction PC.
- `s_rs1_data` input 32: rs1 read data.
- `s_rs2_data` input 32: rs2 read data.
- `m_valid` output 1: output entry valid.
- `m_ready` input 1: execute stage accepts.
- `m_alu_ctrl` output 4: ALU control code.
- `m_op_a` output 32: ALU operand A.
- `m_op_b` output 32: ALU operand B.
- `m_pc` output 32: PC of the entry.
- `m_rd` output 5: destination register (instr[11:7]).
- `m_illegal` output 1: instruction not executable by the ALU.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0100, SLL 0101, SRL 0110, SLT 0111.
- Immediates are sign-extended to 32 bits: I, S, B, U, J formats.
- **OP (0110011):**
  - funct7=0000000 decodes by funct3: 000 ADD, 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000 with funct3=000 decodes as SUB.
  - op_a=rs1, op_b=rs2.
- **OP-IMM (0010011):** same mapping as OP, with op_b=imm_I.
  - SLLI/SRLI require funct7=0; op_b={27'b0,shamt}.
- **LOAD (0000011) / STORE (0100011):** ADD, op_a=rs1, op_b=imm_I or imm_S.
- **BRANCH (1100011):** op_a=rs1, op_b=rs2.
  - BEQ/BNE decode as SUB; the zero flag gives the result.
  - BLT/BGE decode as SLT.
- **LUI:** ADD, op_a=0, op_b=imm_U.
- **AUIPC:** ADD, op_a=pc, op_b=imm_U.
- **JAL/JALR:** ADD, op_a=pc, op_b=4 (link value).
- **Illegal** (m_illegal=1, m_alu_ctrl=ILLEGAL_CTRL, operands 0): SLTU, SLTIU, SRA, SRAI, BLTU, BGEU, any other funct7, and any other opcode. Illegal entries still flow through the handshake.
- **Buffer:** main output register plus one skid register.
  - Accept occurs when s_valid && s_ready.
  - If the output register is empty, or is being drained (m_ready), the decoded entry loads into the output register.
  - Otherwise it loads into the skid register.
  - When the output register drains and the skid is full, the skid entry moves to the output register.
- s_ready = !skid_valid, driven from a register.
- Output data is stable while m_valid && !m_ready (AXI-style hold). s_valid may drop without a transfer.

## Timing
- Latency: an entry accepted at edge N is visible on m_* after edge N; m_valid=1 in cycle N+1.
- Throughput: one entry per cycle while m_ready=1.
- Reset (rst_n low at an edge) clears the state. Values after that edge:
  - m_valid=0, skid empty, s_ready=1.
  - m_alu_ctrl=0, m_op_a=0, m_op_b=0, m_pc=0, m_rd=0, m_illegal=0.
- Reset mid-transfer discards both entries; no output entry is produced for any entry pending at reset.
- Flush at edge N empties both entries: m_valid=0 and s_ready=1 after N. An s_valid beat presented in the flush cycle is dropped.
- Priority: reset > flush > accept/drain.
- Simultaneous accept and drain with the skid empty: the new entry replaces the output register, m_valid stays 1, and no bubble occurs.
- Skid full with m_ready=0: s_ready=0 and inputs are ignored. The first cycle with m_ready=1 shifts the skid to the output, and s_ready=1 next cycle.

## Test plan
- **ADDI x1,x2,-5:** s_instr=0xFFB10093, rs1=0x10, m_ready=1.
  - Next cycle: m_valid=1, ctrl=0010, op_a=0x10, op_b=0xFFFFFFFB, rd=1, illegal=0.
- **Back-to-back stream:**
  - SUB x1,x2,x3 (0x403100B3): ctrl=0100, op_a=rs1, op_b=rs2.
  - LUI x5,0x12345 (0x123452B7): ctrl=0010, op_a=0, op_b=0x12345000, rd=5.
  - Both issue in consecutive cycles with no bubbles.
- **Backpressure:** hold m_ready=0 and send 3 entries.
  - Two are accepted; s_ready=0 on the cycle after the 2nd acceptance.
  - m_* hold the 1st entry.
  - Releasing m_ready drains the entries in order with none lost.
- **Illegal decode:** SLTU (0x002130B3), then opcode 0x7F.
  - Both give m_illegal=1, ctrl=1111, op_a=op_b=0.
  - A subsequent legal instruction decodes normally.
- **Branches:** BLT gives ctrl=0111; BEQ gives ctrl=0100; JAL at pc=0x100 gives op_a=0x100, op_b=4, ctrl=0010.
- **Flush and reset:**
  - With both entries full, assert flush: next cycle m_valid=0, s_ready=1.
  - Repeat with rst_n=0: all outputs read 0 and s_ready=1 after the edge.
